// File: rtl/seq_det_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_scheduler
// Purpose  : Word-level sequencer for an external serial Moore "1001"
//            overlap detector. Each accepted word is scanned in five steps:
//            1. Clear the detector for one cycle.
//            2. Shift the word MSB-first into the detector.
//            3. Collect the detector's q pulses into a hit map and a count.
//            4. Present the result until the consumer takes it.
//            5. Add the count to a saturating lifetime total.
// Ports    : clk                  - system clock, rising edge
//            reset                - asynchronous active-low reset
//            in_valid / in_ready  - word input handshake
//            in_data[W-1:0]       - word to scan, in_data[W-1] shifted first
//            det_reset            - registered active-low detector reset
//            ser_in               - registered serial bit to the detector
//            det_q                - detector Moore output
//            out_valid/out_ready  - result handshake
//            out_hitmap[W-1:0]    - bit k set when the pattern completed on
//                                   shift-order bit k
//            out_count[CW-1:0]    - popcount of out_hitmap
//            total_hits[TW-1:0]   - saturating sum of consumed counts
// Revision : 1.0 - initial release
// ============================================================================
module seq_det_scheduler #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1),
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          det_reset,
  output logic          ser_in,
  input  logic          det_q,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_hitmap,
  output logic [CW-1:0] out_count,
  output logic [TW-1:0] total_hits
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);
  localparam logic [TW-1:0] TOT_MAX  = {TW{1'b1}};

  state_t        state_q, state_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] idx_q,   idx_d;
  logic [W-1:0]  hitmap_q, hitmap_d;
  logic [CW-1:0] count_q,  count_d;
  logic [TW-1:0] total_q,  total_d;
  logic          ser_q,    ser_d;
  logic          detrst_q, detrst_d;

  logic [TW:0]   sum_w;
  logic [CW-1:0] q_inc_w;

  // One extra bit catches the carry out of the lifetime total.
  assign sum_w   = {1'b0, total_q} + {{(TW + 1 - CW){1'b0}}, count_q};
  assign q_inc_w = {{(CW - 1){1'b0}}, det_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      idx_q    <= '0;
      hitmap_q <= '0;
      count_q  <= '0;
      total_q  <= '0;
      ser_q    <= 1'b0;
      detrst_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      idx_q    <= idx_d;
      hitmap_q <= hitmap_d;
      count_q  <= count_d;
      total_q  <= total_d;
      ser_q    <= ser_d;
      detrst_q <= detrst_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    hitmap_d = hitmap_q;
    count_d  = count_q;
    total_d  = total_q;
    ser_d    = 1'b0;
    detrst_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d  = in_data;
          hitmap_d = '0;
          count_d  = '0;
          idx_d    = '0;
          detrst_d = 1'b0;
          state_d  = CLR;
        end
      end
      CLR: begin
        // Present the first bit as the detector leaves reset.
        ser_d   = shreg_q[W-1];
        state_d = SHIFT;
      end
      SHIFT: begin
        shreg_d = shreg_q << 1;
        idx_d   = idx_q + CW'(1);
        // det_q now reflects the bit shifted in the previous cycle.
        if (idx_q != '0) begin
          hitmap_d[idx_q - CW'(1)] = det_q;
          count_d                  = count_q + q_inc_w;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          ser_d = shreg_q[W-2];
        end
      end
      DRAIN: begin
        hitmap_d[W-1] = det_q;
        count_d       = count_q + q_inc_w;
        state_d       = DONE;
      end
      DONE: begin
        if (out_ready) begin
          total_d = sum_w[TW] ? TOT_MAX : sum_w[TW-1:0];
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign det_reset  = detrst_q;
  assign ser_in     = ser_q;
  assign out_hitmap = hitmap_q;
  assign out_count  = count_q;
  assign total_hits = total_q;

endmodule
`default_nettype wire
